matrix_nms: RTL and testbench

//  Non-maximum suppression stage of the canny pipeline; consumes the
//  {magnitude[7:0], direction[1:0]} pixel stream produced by the sobel stage.
//  Two line buffers and a 3x3 window compare each centre magnitude with its two

---
 rtl/canny_pkg.sv | 16 +
 rtl/line_buf.sv | 28 ++
 rtl/matrix_nms.sv | 142 ++++++++++++++
 tb/tb_matrix_nms.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/canny_pkg.sv
// Shared definitions for the canny pipeline stages: direction codes and
// default picture geometry.
package canny_pkg;

   // Default geometry of the picture stream.
   localparam int PIC_WIDTH  = 250;
   localparam int PIC_HEIGHT = 250;
   localparam int WIDTH      = 8;

   // Quantised gradient direction codes produced by the sobel stage.
   localparam logic [1:0] DIR_H    = 2'd0;  // compare left / right
   localparam logic [1:0] DIR_D45  = 2'd1;  // compare up-right / down-left
   localparam logic [1:0] DIR_V    = 2'd2;  // compare up / down
   localparam logic [1:0] DIR_D135 = 2'd3;  // compare up-left / down-right

endpackage

// File: rtl/line_buf.sv
// Enable-gated shift register used as a line delay. The output is the entry
// pushed DEPTH enabled beats ago, so it is readable in the same beat that
// the matching pixel of the next line arrives. Contents are not reset.
module line_buf #(
   parameter int DEPTH = canny_pkg::PIC_WIDTH,
   parameter int W     = canny_pkg::WIDTH + 2
)(
   input  logic         clk,
   input  logic         i_en,
   input  logic [W-1:0] i_din,
   output logic [W-1:0] o_dout
);

   logic [W-1:0] r_mem [DEPTH];

   // Shift one position per enabled beat; newest entry at index 0.
   always_ff @(posedge clk) begin
      if (i_en) begin
         r_mem[0] <= i_din;
         for (int i = 1; i < DEPTH; i++) begin
            r_mem[i] <= r_mem[i-1];
         end
      end
   end

   assign o_dout = r_mem[DEPTH-1];

endmodule

// File: rtl/matrix_nms.sv
// Non-maximum suppression stage. Builds a 3x3 window of {mag, dir} pixels
// from two line delays and keeps the centre magnitude only when it is not
// smaller than both neighbours along its gradient direction.
// Handshake: din is consumed on every cycle valid_in is high (no backpressure);
// valid_out follows valid_in by exactly two cycles and qualifies dout, which
// holds its last value while valid_out is low.
module matrix_nms #(
   parameter int PIC_WIDTH  = canny_pkg::PIC_WIDTH,
   parameter int PIC_HEIGHT = canny_pkg::PIC_HEIGHT,
   parameter int WIDTH      = canny_pkg::WIDTH
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             valid_in,
   input  logic [WIDTH+1:0] din,
   output logic             valid_out,
   output logic [WIDTH-1:0] dout
);

   import canny_pkg::*;

   localparam int CW = (PIC_WIDTH  > 1) ? $clog2(PIC_WIDTH)  : 1;
   localparam int RW = (PIC_HEIGHT > 1) ? $clog2(PIC_HEIGHT) : 1;

   logic [CW-1:0]    r_col_cnt;
   logic [RW-1:0]    r_row_cnt;
   logic [WIDTH+1:0] w_tap [3];
   logic [WIDTH+1:0] r_win [3][3];
   logic             r_border;
   logic             r_valid_d1;
   logic             r_valid_out;
   logic [WIDTH-1:0] r_dout;

   logic [WIDTH-1:0] w_mag_c;
   logic [WIDTH-1:0] w_n1;
   logic [WIDTH-1:0] w_n2;
   logic [WIDTH-1:0] w_nms;

   // Tap 0 is the incoming row r, taps 1/2 are rows r-1 and r-2.
   assign w_tap[0] = din;

   line_buf #(.DEPTH(PIC_WIDTH), .W(WIDTH+2)) u_buf1 (
      .clk    (clk),
      .i_en   (valid_in),
      .i_din  (w_tap[0]),
      .o_dout (w_tap[1])
   );

   line_buf #(.DEPTH(PIC_WIDTH), .W(WIDTH+2)) u_buf2 (
      .clk    (clk),
      .i_en   (valid_in),
      .i_din  (w_tap[1]),
      .o_dout (w_tap[2])
   );

   // Raster position of the pixel currently on din; holds through gaps.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_col_cnt <= '0;
         r_row_cnt <= '0;
      end else if (valid_in) begin
         if (r_col_cnt == CW'(PIC_WIDTH - 1)) begin
            r_col_cnt <= '0;
            if (r_row_cnt == RW'(PIC_HEIGHT - 1)) begin
               r_row_cnt <= '0;
            end else begin
               r_row_cnt <= r_row_cnt + 1'b1;
            end
         end else begin
            r_col_cnt <= r_col_cnt + 1'b1;
         end
      end
   end

   // 3x3 window shift plus border flag for the centre that this beat creates.
   // Column index 0 is the newest (rightmost) column, row index 2 the top row.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
               r_win[i][j] <= '0;
            end
         end
         r_border <= 1'b0;
      end else if (valid_in) begin
         for (int i = 0; i < 3; i++) begin
            r_win[i][0] <= w_tap[i];
            r_win[i][1] <= r_win[i][0];
            r_win[i][2] <= r_win[i][1];
         end
         r_border <= (r_row_cnt <= RW'(1)) || (r_col_cnt <= CW'(1));
      end
   end

   // Select the two neighbours along the centre's direction and suppress.
   always_comb begin
      w_mag_c = r_win[1][1][WIDTH+1:2];
      w_n1    = '0;
      w_n2    = '0;
      case (r_win[1][1][1:0])
         DIR_H: begin
            w_n1 = r_win[1][2][WIDTH+1:2];
            w_n2 = r_win[1][0][WIDTH+1:2];
         end
         DIR_D45: begin
            w_n1 = r_win[2][0][WIDTH+1:2];
            w_n2 = r_win[0][2][WIDTH+1:2];
         end
         DIR_V: begin
            w_n1 = r_win[2][1][WIDTH+1:2];
            w_n2 = r_win[0][1][WIDTH+1:2];
         end
         default: begin
            w_n1 = r_win[2][2][WIDTH+1:2];
            w_n2 = r_win[0][0][WIDTH+1:2];
         end
      endcase
      w_nms = '0;
      if (!r_border && (w_mag_c >= w_n1) && (w_mag_c >= w_n2)) begin
         w_nms = w_mag_c;
      end
   end

   // Two-stage valid pipe; dout only updates when a result is produced.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid_d1  <= 1'b0;
         r_valid_out <= 1'b0;
         r_dout      <= '0;
      end else begin
         r_valid_d1  <= valid_in;
         r_valid_out <= r_valid_d1;
         if (r_valid_d1) begin
            r_dout <= w_nms;
         end
      end
   end

   assign valid_out = r_valid_out;
   assign dout      = r_dout;

endmodule

// File: tb/tb_matrix_nms.sv
// Directed bench for matrix_nms on an 8x6 picture. Expected outputs come from
// an image-coordinate reference model and are queued as pixels are driven.
module tb_matrix_nms;

   localparam int PW = 8;
   localparam int PH = 6;
   localparam int W  = 8;

   logic           clk;
   logic           rst_n;
   logic           valid_in;
   logic [W+1:0]   din;
   logic           valid_out;
   logic [W-1:0]   dout;

   logic [W-1:0]   exp_q [$];
   logic [W-1:0]   out_log [$];
   logic [W-1:0]   ref_log [$];
   logic [W-1:0]   last_dout;
   logic [W-1:0]   img_m [PH][PW];
   logic [1:0]     img_d [PH][PW];
   int             total;
   int             bad;

   matrix_nms #(.PIC_WIDTH(PW), .PIC_HEIGHT(PH), .WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .valid_in  (valid_in),
      .din       (din),
      .valid_out (valid_out),
      .dout      (dout)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // reference model: expected dout for the output beat caused by input pixel (r,c)
   function automatic logic [W-1:0] model(input int r, input int c);
      int cr, cc, r1, c1, r2, c2;
      logic [W-1:0] mc;
      if (r <= 1 || c <= 1) return '0;
      cr = r - 1;
      cc = c - 1;
      case (img_d[cr][cc])
         2'd0:    begin r1 = cr;   c1 = cc-1; r2 = cr;   c2 = cc+1; end
         2'd1:    begin r1 = cr-1; c1 = cc+1; r2 = cr+1; c2 = cc-1; end
         2'd2:    begin r1 = cr-1; c1 = cc;   r2 = cr+1; c2 = cc;   end
         default: begin r1 = cr-1; c1 = cc-1; r2 = cr+1; c2 = cc+1; end
      endcase
      mc = img_m[cr][cc];
      if (mc >= img_m[r1][c1] && mc >= img_m[r2][c2]) return mc;
      return '0;
   endfunction

   task automatic fill(input logic [W-1:0] m, input logic [1:0] d);
      for (int r = 0; r < PH; r++)
         for (int c = 0; c < PW; c++) begin
            img_m[r][c] = m;
            img_d[r][c] = d;
         end
   endtask

   // driver tasks (inputs change at posedge+1)
   task automatic drive_pix(input int r, input int c, input bit gaps);
      if (gaps && $urandom_range(0, 1) == 1) begin
         valid_in = 1'b0;
         repeat ($urandom_range(1, 5)) @(posedge clk);
         #1;
      end
      valid_in = 1'b1;
      din      = {img_m[r][c], img_d[r][c]};
      exp_q.push_back(model(r, c));
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      valid_in = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk("queue_drained", exp_q.size(), 0);
   endtask

   task automatic do_reset();
      valid_in = 1'b0;
      rst_n    = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic run_frame(input bit gaps);
      out_log.delete();
      for (int r = 0; r < PH; r++)
         for (int c = 0; c < PW; c++)
            drive_pix(r, c, gaps);
      drain();
      chk("frame_beats", out_log.size(), PH * PW);
   endtask

   // scoreboard: pop on each valid_out, check hold and reset values otherwise
   always @(negedge clk) begin
      if (!rst_n) begin
         chk("rst_valid_out", valid_out, 0);
         chk("rst_dout", dout, 0);
         last_dout = '0;
      end else if (valid_out) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_valid_out", 1, 0);
         end else begin
            chk("dout", dout, exp_q.pop_front());
         end
         out_log.push_back(dout);
         last_dout = dout;
      end else begin
         chk("dout_hold", dout, last_dout);
      end
   end

   // watchdog
   initial begin
      #500000;
      $display("FAIL watchdog expired got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      total     = 0;
      bad       = 0;
      rst_n     = 1'b0;
      valid_in  = 1'b0;
      din       = '0;
      last_dout = '0;

      // 1: valid_in during reset is ignored; latency after release is 2 cycles
      repeat (2) @(posedge clk);
      #1;
      valid_in = 1'b1;
      din      = {8'd77, 2'd0};
      repeat (4) @(posedge clk);
      #1;
      valid_in = 1'b0;
      rst_n    = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      fill(8'd0, 2'd0);
      valid_in = 1'b1;
      exp_q.push_back(8'd0);
      @(posedge clk);
      #1;
      valid_in = 1'b0;
      chk("lat_cycle1", valid_out, 0);
      @(posedge clk);
      #1;
      chk("lat_cycle2", valid_out, 1);
      @(posedge clk);
      #1;
      chk("lat_cycle3", valid_out, 0);
      drain();

      // 2: uniform frame, ties kept in interior, borders zero
      do_reset();
      fill(8'd100, 2'd0);
      run_frame(1'b0);
      chk("uni_r0b5", out_log[0*PW+5], 0);
      chk("uni_r1b4", out_log[1*PW+4], 0);
      chk("uni_r3b1", out_log[3*PW+1], 0);
      chk("uni_r2b2", out_log[2*PW+2], 100);
      chk("uni_r5b7", out_log[5*PW+7], 100);

      // 3: vertical ridge in image col 4; the flat 50 field keeps ties
      do_reset();
      fill(8'd50, 2'd0);
      for (int r = 0; r < PH; r++) img_m[r][4] = 8'd200;
      run_frame(1'b0);
      for (int r = 2; r < PH; r++) begin
         chk("vr_b5", out_log[r*PW+5], 200);
         chk("vr_b4", out_log[r*PW+4], 0);
         chk("vr_b6", out_log[r*PW+6], 0);
      end
      chk("vr_r3b2", out_log[3*PW+2], 50);
      ref_log = out_log;

      // 4: horizontal ridge in image row 3, vertical compare
      do_reset();
      fill(8'd60, 2'd2);
      for (int c = 0; c < PW; c++) img_m[3][c] = 8'd180;
      run_frame(1'b0);
      for (int b = 2; b < PW; b++) begin
         chk("hr_r4", out_log[4*PW+b], 180);
         chk("hr_r3", out_log[3*PW+b], 0);
         chk("hr_r5", out_log[5*PW+b], 0);
      end
      // same image with horizontal compare: every interior pixel is a tie
      do_reset();
      for (int r = 0; r < PH; r++)
         for (int c = 0; c < PW; c++) img_d[r][c] = 2'd0;
      run_frame(1'b0);
      chk("hr0_r4b3", out_log[4*PW+3], 180);
      chk("hr0_r2b6", out_log[2*PW+6], 60);
      chk("hr0_r5b2", out_log[5*PW+2], 60);

      // 5: diagonal compare; centre (2,3) shows up at output row 3 beat 4
      do_reset();
      fill(8'd10, 2'd0);
      img_m[2][3] = 8'd150;
      img_d[2][3] = 2'd1;
      img_m[1][4] = 8'd200;
      run_frame(1'b0);
      chk("diag_lose", out_log[3*PW+4], 0);
      do_reset();
      img_m[1][4] = 8'd150;
      run_frame(1'b0);
      chk("diag_tie", out_log[3*PW+4], 150);

      // 6: ridge frame with random gaps must match the gap-free sequence
      do_reset();
      fill(8'd50, 2'd0);
      for (int r = 0; r < PH; r++) img_m[r][4] = 8'd200;
      run_frame(1'b1);
      for (int k = 0; k < PH * PW; k++) chk("gap_vs_ref", out_log[k], ref_log[k]);
      // partial frame, reset in the middle of row 2, then a full new frame
      for (int r = 0; r < 2; r++)
         for (int c = 0; c < PW; c++) drive_pix(r, c, 1'b1);
      for (int c = 0; c < 4; c++) drive_pix(2, c, 1'b1);
      drain();
      do_reset();
      run_frame(1'b1);
      for (int k = 0; k < PH * PW; k++) chk("post_rst_vs_ref", out_log[k], ref_log[k]);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
